uart_rx_engine: RTL and testbench

//  Receive engine for the UART; the stage downstream of the transmit engine on the serial line.
//  It deserialises the Rx line into a byte using the same frame controls as the transmitter (eight, pen, ohel, baud).
//  It flags parity, framing and overrun errors, and holds the byte until the host acknowledges it.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_bit_timer.sv | 53 +++++
 rtl/uart_rx_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// baud-rate table and the bit-time helper used by the bit timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Width of a bit-time count; 300 baud at 100 MHz needs 333333 clocks.
  localparam int BIT_CNT_W = 19;

  // Parity sense as seen on the ohel input.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Rate select codes 11..15 all map to the fastest rate.
  localparam int unsigned BAUD_RATE [0:15] = '{
    300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
    115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600
  };

  // Clocks per bit, truncated.
  function automatic logic [BIT_CNT_W-1:0] bit_count(input int unsigned clk_hz,
                                                     input logic [3:0]  baud);
    int unsigned n;
    n = clk_hz / BAUD_RATE[baud];
    return n[BIT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Sample-point timer for the UART receiver. A load on start arms the counter
// for half a bit time so the first tick lands mid-start-bit; every later tick
// follows one full bit time after the previous one.
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] baud,
  input  logic       enable,
  output logic       tick
);

  logic [BIT_CNT_W-1:0] n_tab [16];
  logic [BIT_CNT_W-1:0] n_full;
  logic [BIT_CNT_W-1:0] n_half;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [BIT_CNT_W-1:0] cnt_d;

  // Constant table of bit times, one entry per rate code.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      n_tab[i] = bit_count(CLK_HZ, 4'(i));
    end
  end

  assign n_full = n_tab[baud];
  assign n_half = n_full >> 1;

  // Terminal count of the down-counter marks a sample point.
  assign tick = enable & ~start & (cnt_q == '0);

  // Next counter value: load half bit on start, reload full bit at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = n_half - 19'd1;
    end else if (enable) begin
      if (cnt_q == '0) cnt_d = n_full - 19'd1;
      else             cnt_d = cnt_q - 19'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises Rx, frames start/data/parity/stop bits,
// and holds the received byte with parity, framing and overrun flags until
// the host strobes clr_rdy.
// Build option RX_MAJORITY_EN: each sample becomes a 2-of-3 vote over
// mid-1, mid and mid+1, which delays every decision by one clock.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | waiting for mid start bit to confirm the start
// DATA   | sampling 7 or 8 data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then straight back to IDLE
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       RxRdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic fall;
  logic tick;
  logic samp_stb;
  logic samp_bit;

  rx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] last_idx;
  logic [7:0] shreg_q, shreg_d;
  logic       perr_pend_q, perr_pend_d;
  logic       eight_q, eight_d;
  logic       pen_q, pen_d;
  logic       ohel_q, ohel_d;
  logic [3:0] baud_q, baud_d;
  logic       start_tmr;
  logic       done;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rdy_q, rdy_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovf_q, ovf_d;

  // Two-flop synchroniser plus one history flop for edge detection; idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= Rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fall = rx_s3_q & ~rx_s2_q;

`ifdef RX_MAJORITY_EN
  logic rx_s4_q;
  logic tick_d_q;

  // Extra history and delayed tick so the vote can include mid+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s4_q  <= 1'b1;
      tick_d_q <= 1'b0;
    end else begin
      rx_s4_q  <= rx_s3_q;
      tick_d_q <= tick;
    end
  end

  assign samp_stb = tick_d_q;
  assign samp_bit = (rx_s2_q & rx_s3_q) | (rx_s2_q & rx_s4_q) | (rx_s3_q & rx_s4_q);
`else
  assign samp_stb = tick;
  assign samp_bit = rx_s2_q;
`endif

  uart_rx_bit_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start_tmr),
    .baud   (start_tmr ? baud : baud_q),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  assign last_idx = eight_q ? 3'd7 : 3'd6;

  // Frame FSM: next state, shift register, frame config latch.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    perr_pend_d = perr_pend_q;
    eight_d     = eight_q;
    pen_d       = pen_q;
    ohel_d      = ohel_q;
    baud_d      = baud_q;
    start_tmr   = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          start_tmr = 1'b1;
          eight_d   = eight;
          pen_d     = pen;
          ohel_d    = ohel;
          baud_d    = baud;
        end
      end
      START: begin
        if (samp_stb) begin
          if (samp_bit) begin
            state_d = IDLE;
          end else begin
            state_d     = DATA;
            bit_idx_d   = 3'd0;
            shreg_d     = 8'h00;
            perr_pend_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (samp_stb) begin
          shreg_d[bit_idx_q] = samp_bit;
          if (bit_idx_q == last_idx) state_d = pen_q ? PARITY : STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (samp_stb) begin
          perr_pend_d = (^shreg_q ^ samp_bit) != ohel_q;
          state_d     = STOP;
        end
      end
      STOP: begin
        if (samp_stb) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and frame-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      perr_pend_q <= 1'b0;
      eight_q     <= 1'b1;
      pen_q       <= 1'b0;
      ohel_q      <= PAR_EVEN;
      baud_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      perr_pend_q <= perr_pend_d;
      eight_q     <= eight_d;
      pen_q       <= pen_d;
      ohel_q      <= ohel_d;
      baud_q      <= baud_d;
    end
  end

  // Host-facing holding registers; a completing frame beats a same-cycle clear.
  always_comb begin
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;
    if (done) begin
      rx_data_d = shreg_q;
      rdy_d     = 1'b1;
      perr_d    = perr_pend_q;
      ferr_d    = ~samp_bit;
      ovf_d     = rdy_q & ~clr_rdy;
    end else if (clr_rdy) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rx_data = rx_data_q;
  assign RxRdy   = rdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at 921600 baud (108 clocks per bit).
module tb_uart_rx_engine;
  import uart_pkg::*;

  localparam int NB = 108;
`ifdef RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Offset inside the stop bit of the last negedge before the completion edge.
  localparam int CLR_OFF = 56 + MAJ;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rx;
  logic       eight, pen, ohel;
  logic [3:0] baud;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       RxRdy, perr, ferr, ovf;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   rdy_model = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_engine #(.CLK_HZ(100_000_000)) dut (
    .clk     (clk),
    .rst     (rst),
    .Rx      (Rx),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .baud    (baud),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .RxRdy   (RxRdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit time on the line, optional 1-clock low glitch at mid-bit,
  // optional clr_rdy on the completion clock, optional latency check.
  task automatic drive_bit(input logic b, input bit glitch, input bit clr_stop, input bit chk_lat);
    for (int i = 0; i < NB; i++) begin
      Rx      = (glitch && i == 54) ? 1'b0 : b;
      clr_rdy = clr_stop && (i == CLR_OFF);
      if (chk_lat && i == CLR_OFF)     chk("lat_before", {7'd0, RxRdy}, 8'd0);
      if (chk_lat && i == CLR_OFF + 1) chk("lat_after",  {7'd0, RxRdy}, 8'd1);
      @(negedge clk);
    end
    clr_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe, input logic od,
                            input logic pbit, input logic stop, input int glitch_idx,
                            input bit clr_stop, input bit chk_lat);
    exp_t x;
    int   nbits;
    x.data = e8 ? d : {1'b0, d[6:0]};
    x.perr = pe && ((^x.data ^ pbit) != od);
    x.ferr = ~stop;
    x.ovf  = rdy_model & ~clr_stop;
    rdy_model = 1'b1;
    exp_q.push_back(x);
    eight = e8; pen = pe; ohel = od; baud = 4'd11;
    nbits = e8 ? 8 : 7;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    // Scramble config mid-frame; the frame must use the latched values.
    eight = ~e8; pen = ~pe; ohel = ~od; baud = 4'd0;
    for (int i = 0; i < nbits; i++) drive_bit(d[i], glitch_idx == i, 1'b0, 1'b0);
    if (pe) drive_bit(pbit, 1'b0, 1'b0, 1'b0);
    drive_bit(stop, 1'b0, clr_stop, chk_lat);
    eight = e8; pen = pe; ohel = od; baud = 4'd11;
  endtask

  task automatic check_frame(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s observed=no_expected expected=frame", tag);
    end else begin
      x = exp_q.pop_front();
      chk({tag, "_data"}, rx_data, x.data);
      chk({tag, "_rdy"},  {7'd0, RxRdy}, 8'd1);
      chk({tag, "_perr"}, {7'd0, perr},  {7'd0, x.perr});
      chk({tag, "_ferr"}, {7'd0, ferr},  {7'd0, x.ferr});
      chk({tag, "_ovf"},  {7'd0, ovf},   {7'd0, x.ovf});
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    rdy_model = 1'b0;
  endtask

  task automatic check_cleared(input string tag, input logic [7:0] data_hold);
    chk({tag, "_rdy"},  {7'd0, RxRdy}, 8'd0);
    chk({tag, "_perr"}, {7'd0, perr},  8'd0);
    chk({tag, "_ferr"}, {7'd0, ferr},  8'd0);
    chk({tag, "_ovf"},  {7'd0, ovf},   8'd0);
    chk({tag, "_data"}, rx_data, data_hold);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; Rx = 1'b1; clr_rdy = 1'b0;
    eight = 1'b1; pen = 1'b1; ohel = PAR_EVEN; baud = 4'd11;
    repeat (3) @(negedge clk);
    check_cleared("reset", 8'h00);
    rst = 1'b1;
    idle(10);

    // 1: 8E1, 0x43 with correct parity, plus completion latency.
    send_frame(8'h43, 1'b1, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, 1'b0, 1'b1);
    check_frame("t1");
    pulse_clr();
    check_cleared("t1_clr", 8'h43);

    // 2: same frame, wrong parity bit.
    send_frame(8'h43, 1'b1, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_frame("t2");
    pulse_clr();

    // 3: 7N1, 0x55 with a low stop bit, then clear.
    send_frame(8'h55, 1'b0, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    check_frame("t3");
    idle(20);
    pulse_clr();
    check_cleared("t3_clr", 8'h55);

    // 4: short low pulse is a false start.
    Rx = 1'b0;
    repeat (40) @(negedge clk);
    Rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_state", 8'(dut.state_q), 8'(IDLE));
    chk("t4_rdy", {7'd0, RxRdy}, 8'd0);
    idle(20);

    // 5: overrun, then clear colliding with completion.
    send_frame(8'h11, 1'b1, 1'b1, PAR_EVEN, ^8'h11, 1'b1, -1, 1'b0, 1'b0);
    check_frame("t5a");
    send_frame(8'h22, 1'b1, 1'b1, PAR_EVEN, ^8'h22, 1'b1, -1, 1'b0, 1'b0);
    check_frame("t5b");
    send_frame(8'h33, 1'b1, 1'b1, PAR_ODD, ~(^8'h33), 1'b1, -1, 1'b1, 1'b0);
    check_frame("t5c");

    // 6: reset during data bit 3, then a clean frame.
    eight = 1'b1; pen = 1'b0; baud = 4'd11;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    Rx = 1'b0;
    repeat (54) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rdy_model = 1'b0;
    check_cleared("t6_rst", 8'h00);
    Rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(20);
    send_frame(8'hA5, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_frame("t6");
    pulse_clr();

    // Break: line held low gives exactly one zero frame with ferr.
    begin
      exp_t x;
      x.data = 8'h00; x.perr = 1'b0; x.ferr = 1'b1; x.ovf = 1'b0;
      exp_q.push_back(x);
      rdy_model = 1'b1;
      eight = 1'b1; pen = 1'b0;
      for (int i = 0; i < 15; i++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
      check_frame("brk");
      chk("brk_state", 8'(dut.state_q), 8'(IDLE));
      idle(20);
      pulse_clr();
    end

`ifdef RX_MAJORITY_EN
    // Single-clock glitch at mid-bit of a 1 data bit is voted out.
    send_frame(8'hA5, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check_frame("glitch");
`endif

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
